spi_device: RTL and testbench
=============================

Name: spi_device

Overview:
- Byte-oriented SPI slave (mode-0 style) clocked directly by the system clock `clk`, which also serves as the serial clock.
- With chip-select `cs` low, shifts in one `mosi` bit per rising edge, MSB first.
- Presents each completed byte on `data_out`, and echoes the previously received byte on `miso`.
- Sits at the edge of the FPGA fabric as a simple command/data receiver.

Parameters:
- DATA_WIDTH, 8, frame length in bits and width of `data_out`/shift registers.

Ports:
- clk  input  1  system clock; all sampling on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- cs  input  1  chip select, active-low; high = bus idle / frame abort.
- mosi  input  1  serial data in, sampled on rising `clk` while `cs`=0.
- miso  output  1  serial data out (echo of last received byte).
- data_out  output  DATA_WIDTH  last completed received frame.

Behaviour:
- Reset (`rst`=0, async):
  - Outputs: `data_out`=0, `miso`=0.
  - Internal state: `rx_shift`=0, `tx_shift`=0, `bit_cnt`=0, state=IDLE.
- States:
  - IDLE (`cs`=1): `bit_cnt` held 0, `rx_shift` cleared, `tx_shift` loaded with `data_out` every cycle, `miso`=0.
  - SHIFT: entered on the first rising edge with `cs`=0.
- SHIFT, each rising edge with `cs`=0:
  - `rx_shift` <= {`rx_shift`[W-2:0], `mosi`}.
  - `tx_shift` <= {`tx_shift`[W-2:0], 0}.
  - `bit_cnt`++.
- Frame completion: on the edge where `bit_cnt`==W-1:
  - `data_out` <= {`rx_shift`[W-2:0], `mosi`}, so `data_out` is valid immediately after the Wth sampling edge (zero extra latency).
  - `bit_cnt` <= 0.
  - `tx_shift` <= the newly completed byte.
- Back-to-back frames: `cs` may remain low; the next edge begins the next frame with no gap cycle.
- `miso` = `tx_shift`[W-1] while `cs`=0 (registered; MSB of the echo byte is present from the first `cs`-low cycle), 0 while `cs`=1.
- Abort: `cs` rising mid-frame discards the partial frame. `data_out` keeps its last completed value; `bit_cnt` returns to 0.
- `cs` is sampled synchronously; a `cs` change takes effect on the next rising edge.
- `mosi` is don't-care while `cs`=1.
- Reset mid-frame: all state cleared immediately; the first frame after reset starts from bit W-1.
- `data_out` changes only on frame completion or reset.

Optional Feature:
- Macro: SPI_DEVICE_LSB_FIRST_EN.
- Defined: receive and echo-transmit are LSB first:
  - `rx_shift` shifts right with `mosi` into bit W-1.
  - `miso` = `tx_shift`[0]; `tx_shift` shifts right.
- Undefined: MSB first as above.
- Frame timing, counters and `cs` behaviour are identical in both modes.

Decomposition:
- Shared package `spi_pkg`:
  - Default DATA_WIDTH constant.
  - State enum typedef (IDLE, SHIFT).
  - Bit-counter width function (clog2 of DATA_WIDTH).
- One natural sub-module `spi_shift_reg`: parameterised shift register with load, shift-enable and serial in/out. Instantiated twice (rx, tx); the top holds the counter, state and `data_out` register.

Test Plan:
- Reset: hold `rst`=0 with `cs`=0 and random `mosi` -> `data_out`=0x00, `miso`=0 throughout.
- Single frame: release reset; `cs`=0; drive 0xBD MSB first, one bit per edge (1,0,1,1,1,1,0,1) -> `data_out`=0xBD right after the 8th edge, unchanged before it; `cs`=1 afterwards keeps 0xBD.
- Echo: after 0xBD, second frame of 0x3C with `cs`=0 -> `miso` emits 1,0,1,1,1,1,0,1 on successive cycles; `data_out`=0x3C at frame end.
- Abort: send 3 bits of 0xFF, raise `cs` for 2 cycles, then a full 0x5A frame -> `data_out` stays at its prior value during the abort, then 0x5A.
- Back-to-back: `cs` held low for 16 bits (0xA5 then 0x0F) -> `data_out`=0xA5 after edge 8, 0x0F after edge 16.
- Reset mid-frame: assert `rst`=0 after 4 bits -> `data_out`=0, `miso`=0. Next full 0x81 frame -> `data_out`=0x81.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared sizing constants, state type and helpers for the SPI device slice.
package spi_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

    // Bit-counter width for a frame of the given length (never narrower than 1).
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/spi_device_if.sv
// SPI pin-level bundle: chip select and serial data plus the received-byte output.
interface spi_device_if #(
    parameter int unsigned DATA_WIDTH = spi_pkg::DEFAULT_DATA_WIDTH
);
    logic                  cs;
    logic                  mosi;
    logic                  miso;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output cs,
        output mosi,
        input  miso,
        input  data_out
    );

    modport slave (
        input  cs,
        input  mosi,
        output miso,
        output data_out
    );
endinterface

// File: rtl/spi_shift_reg.sv
// Shift register with clear, parallel load and serial in/out.
// SPI_DEVICE_LSB_FIRST_EN selects right shifts (LSB first); default is left shifts (MSB first).
module spi_shift_reg #(
    parameter int unsigned WIDTH = spi_pkg::DEFAULT_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift_en,
    input  logic             i_sin,
    output logic             o_sout_c,
    output logic [WIDTH-1:0] o_next_c
);
    logic [WIDTH-1:0] r_q;

`ifdef SPI_DEVICE_LSB_FIRST_EN
    assign o_next_c = {i_sin, r_q[WIDTH-1:1]};
    assign o_sout_c = r_q[0];
`else
    assign o_next_c = {r_q[WIDTH-2:0], i_sin};
    assign o_sout_c = r_q[WIDTH-1];
`endif

    // Clear beats load beats shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_data;
        end else if (i_shift_en) begin
            r_q <= o_next_c;
        end
    end
endmodule

// File: rtl/spi_device.sv
// Byte-oriented SPI slave clocked by clk: receives frames on mosi, echoes the last byte on miso.
// Bit order is MSB first unless SPI_DEVICE_LSB_FIRST_EN is defined (see spi_shift_reg).
module spi_device
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    spi_device_if.slave        bus
);
    localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);

    spi_state_e              r_state;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic                    r_miso;

    logic                    w_active;
    logic [CNT_W-1:0]        w_cnt_cur;
    logic                    w_frame_done;
    logic [DATA_WIDTH-1:0]   w_rx_next;
    logic                    w_tx_sout;
    logic                    w_rx_sout_unused;
    logic [DATA_WIDTH-1:0]   w_tx_next_unused;

    assign w_active     = !bus.cs;
    assign w_cnt_cur    = (r_state == SHIFT) ? r_bit_cnt : '0;
    assign w_frame_done = w_active && (w_cnt_cur == CNT_W'(DATA_WIDTH - 1));

    // Receive path: cleared while idle, shifts mosi in on every selected edge.
    spi_shift_reg #(.WIDTH(DATA_WIDTH)) u_rx (
        .clk         (clk),
        .rst_n       (rst),
        .i_clear     (!w_active),
        .i_load      (1'b0),
        .i_load_data ('0),
        .i_shift_en  (w_active),
        .i_sin       (bus.mosi),
        .o_sout_c    (w_rx_sout_unused),
        .o_next_c    (w_rx_next)
    );

    // Echo path: tracks data_out while idle, reloads with the fresh byte at frame end.
    spi_shift_reg #(.WIDTH(DATA_WIDTH)) u_tx (
        .clk         (clk),
        .rst_n       (rst),
        .i_clear     (1'b0),
        .i_load      (!w_active || w_frame_done),
        .i_load_data (w_active ? w_rx_next : r_data_out),
        .i_shift_en  (w_active),
        .i_sin       (1'b0),
        .o_sout_c    (w_tx_sout),
        .o_next_c    (w_tx_next_unused)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_data_out <= '0;
            r_miso     <= 1'b0;
        end else if (!w_active) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_miso    <= 1'b0;
        end else begin
            r_state <= SHIFT;
            r_miso  <= w_tx_sout;
            if (w_frame_done) begin
                r_bit_cnt  <= '0;
                r_data_out <= w_rx_next;
            end else begin
                r_bit_cnt <= w_cnt_cur + CNT_W'(1);
            end
        end
    end

    assign bus.miso     = r_miso;
    assign bus.data_out = r_data_out;
endmodule

// File: tb/tb_spi_device.sv
// Scoreboard bench for spi_device: directed scenarios plus random frames, aborts and resets.
module tb_spi_device;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic [31:0]  cyc;
        logic [W-1:0] data;
        logic         miso;
    } exp_t;

    logic clk;
    logic rst;
    logic cs;
    logic mosi;

    spi_device_if #(.DATA_WIDTH(W)) bus ();
    assign bus.cs   = cs;
    assign bus.mosi = mosi;

    spi_device #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;

    // Reference model: bits collected per frame, last byte, and echo progress.
    logic        m_bits[$];
    logic [W-1:0] m_data = '0;
    logic [W-1:0] m_echo = '0;
    int unsigned  m_idx  = 0;

    function automatic logic order_bit(input logic [W-1:0] v, input int unsigned i);
`ifdef SPI_DEVICE_LSB_FIRST_EN
        return v[i];
`else
        return v[W-1-i];
`endif
    endfunction

    function automatic logic [W-1:0] assemble(input logic b[$]);
        logic [W-1:0] v = '0;
        for (int i = 0; i < int'(W); i++) v[W-1-order_idx(i)] = b[i];
        return v;
    endfunction

    function automatic int unsigned order_idx(input int i);
`ifdef SPI_DEVICE_LSB_FIRST_EN
        return W - 1 - i;
`else
        return i;
`endif
    endfunction

    // Drive one cycle at the falling edge and predict outputs after the next rising edge.
    task automatic step(input logic r, input logic c, input logic m);
        logic e_miso;
        @(negedge clk);
        rst = r; cs = c; mosi = m;
        e_miso = 1'b0;
        if (!r) begin
            m_data = '0; m_echo = '0; m_idx = 0; m_bits.delete();
        end else if (c) begin
            m_bits.delete(); m_echo = m_data; m_idx = 0;
        end else begin
            e_miso = order_bit(m_echo, m_idx);
            m_idx++;
            m_bits.push_back(m);
            if (m_bits.size() == W) begin
                m_data = assemble(m_bits);
                m_echo = m_data; m_idx = 0; m_bits.delete();
            end
        end
        cyc++;
        exp_q.push_back('{cyc: cyc, data: m_data, miso: e_miso});
    endtask

    task automatic send_bits(input logic [W-1:0] v, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b0, order_bit(v, i));
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)));
    endtask

    // Monitor: compare both outputs one time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.data_out !== e.data) begin
                    failures++;
                    $display("FAIL data_out cyc=%0d got=%h exp=%h", e.cyc, bus.data_out, e.data);
                end
                checks++;
                if (bus.miso !== e.miso) begin
                    failures++;
                    $display("FAIL miso cyc=%0d got=%b exp=%b", e.cyc, bus.miso, e.miso);
                end
            end
        end
    end

    initial begin
        int unsigned guard;
        rst = 1'b0; cs = 1'b1; mosi = 1'b0;

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        step(1'b1, 1'b1, 1'b0);

        send_bits(8'hBD, W); idle(2);
        send_bits(8'h3C, W); idle(1);
        send_bits(8'hFF, 3); idle(2);
        send_bits(8'h5A, W); idle(1);
        send_bits(8'hA5, W); send_bits(8'h0F, W); idle(1);
        send_bits(8'hC3, 4);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < int'(W); i++) step(1'b1, 1'b0, order_bit(8'h81, i - 1));
        step(1'b1, 1'b0, order_bit(8'h81, W - 1));
        idle(1);
        send_bits(8'h81, W); idle(1);

        repeat (60) begin
            logic [W-1:0] b;
            int unsigned  kind;
            b    = W'($urandom);
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1:    begin send_bits(b, W); idle($urandom_range(1, 3)); end
                2, 3:    send_bits(b, W);
                4:       begin send_bits(b, $urandom_range(1, W - 1)); idle($urandom_range(1, 2)); end
                default: begin
                    send_bits(b, $urandom_range(0, W - 1));
                    step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    step(1'b1, 1'b1, 1'b0);
                end
            endcase
        end
        idle(2);

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk);
            #2;
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
